// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending datapath:
//   - coin denomination codes (COIN_5 .. COIN_500, COIN_NONE)
//   - coin_value(): code -> rupee value, same decoder the vending FSM uses
//   - disp_state_t: change_dispenser state encoding
// ---------------------------------------------------------------------------
package vending_pkg;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_5    = 3'b001;
    localparam logic [2:0] COIN_10   = 3'b010;
    localparam logic [2:0] COIN_50   = 3'b011;
    localparam logic [2:0] COIN_100  = 3'b100;
    localparam logic [2:0] COIN_500  = 3'b101;

    // Denominations are indexed 0..NUM_DENOM-1 as (code - 1).
    localparam int NUM_DENOM = 5;

    typedef enum logic [1:0] {
        DISP_IDLE   = 2'd0,
        DISP_SELECT = 2'd1,
        DISP_ISSUE  = 2'd2,
        DISP_FINISH = 2'd3
    } disp_state_t;

    // Rupee value of a coin code, zero-extended to 16 bits.
    // Unused codes decode to 0.
    function automatic logic [15:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_5:   coin_value = 16'd5;
            COIN_10:  coin_value = 16'd10;
            COIN_50:  coin_value = 16'd50;
            COIN_100: coin_value = 16'd100;
            COIN_500: coin_value = 16'd500;
            default:  coin_value = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// ---------------------------------------------------------------------------
// change_dispenser_if
// Signal bundle between the change dispenser and its environment
// (vending FSM, coin hopper, restock logic).
//   change_in/change_load   : payout request from the FSM
//   coin_out/coin_valid/
//   coin_ready              : coin handshake to the hopper
//   restock_coin/restock_en : add one coin to the inventory
//   busy/done/short_flag/
//   shortfall/load_drop     : status back to the FSM
// Modports: slave = the dispenser, master = the environment driving it.
// ---------------------------------------------------------------------------
interface change_dispenser_if;

    logic [15:0] change_in;
    logic        change_load;
    logic [2:0]  coin_out;
    logic        coin_valid;
    logic        coin_ready;
    logic [2:0]  restock_coin;
    logic        restock_en;
    logic        busy;
    logic        done;
    logic        short_flag;
    logic [15:0] shortfall;
    logic        load_drop;

    modport master (
        output change_in, change_load, coin_ready, restock_coin, restock_en,
        input  coin_out, coin_valid, busy, done, short_flag, shortfall, load_drop
    );

    modport slave (
        input  change_in, change_load, coin_ready, restock_coin, restock_en,
        output coin_out, coin_valid, busy, done, short_flag, shortfall, load_drop
    );

endinterface

// File: rtl/coin_inventory.sv
// ---------------------------------------------------------------------------
// coin_inventory
// One CNT_W-bit counter per denomination.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   restock_en/restock_coin: +1 on the addressed denomination (saturating);
//                            codes 000, 110, 111 are ignored
//   dec_en/dec_coin        : -1 on the addressed denomination (coin issued)
//   avail[i]               : denomination (code i+1) has at least one coin
// A simultaneous restock and issue of the same denomination leaves the
// count unchanged.
// ---------------------------------------------------------------------------
module coin_inventory
    import vending_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restock_en,
    input  logic [2:0]           restock_coin,
    input  logic                 dec_en,
    input  logic [2:0]           dec_coin,
    output logic [NUM_DENOM-1:0] avail
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);

    logic [CNT_W-1:0]     cnt [NUM_DENOM];
    logic [NUM_DENOM-1:0] inc;
    logic [NUM_DENOM-1:0] dec;

    always_comb begin
        inc   = '0;
        dec   = '0;
        avail = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            inc[i]   = restock_en && (restock_coin == 3'(i + 1));
            // An empty counter never decrements, so it cannot wrap.
            dec[i]   = dec_en && (dec_coin == 3'(i + 1)) && (cnt[i] != '0);
            avail[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                cnt[i] <= CNT_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                if (inc[i] && !dec[i]) begin
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out a 16-bit change amount as physical coins, largest denomination
// first, limited by the coin inventory. Coins go to the hopper one at a time
// over a valid/ready handshake; a done pulse ends every payout and reports
// any amount that could not be paid.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : change_dispenser_if.slave (request, coin handshake, restock,
//            status)
// Parameters:
//   CNT_W      : width of each inventory counter
//   INIT_COUNT : inventory of every denomination after reset
// ---------------------------------------------------------------------------
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 20
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    disp_state_t          state;
    disp_state_t          state_nxt;
    logic [15:0]          remaining;
    logic [15:0]          remaining_nxt;
    logic [15:0]          shortfall_q;
    logic [15:0]          shortfall_nxt;
    logic                 short_q;
    logic                 short_nxt;
    logic [2:0]           coin_q;
    logic [2:0]           coin_nxt;
    logic                 load_drop_q;
    logic [NUM_DENOM-1:0] avail;
    logic                 sel_found;
    logic [2:0]           sel_code;
    logic                 accept;

    assign accept = (state == DISP_ISSUE) && bus.coin_ready;

    coin_inventory #(
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inv (
        .clk          (clk),
        .reset        (reset),
        .restock_en   (bus.restock_en),
        .restock_coin (bus.restock_coin),
        .dec_en       (accept),
        .dec_coin     (coin_q),
        .avail        (avail)
    );

    // Greedy pick: scan from the largest denomination down and take the
    // first one that is in stock and does not exceed the remaining amount.
    // Because value <= remaining is required, remaining can never underflow.
    always_comb begin
        sel_found = 1'b0;
        sel_code  = COIN_NONE;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (!sel_found && avail[i] && (coin_value(3'(i + 1)) <= remaining)) begin
                sel_found = 1'b1;
                sel_code  = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DISP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        shortfall_nxt = shortfall_q;
        short_nxt     = short_q;
        coin_nxt      = coin_q;
        case (state)
            DISP_IDLE: begin
                // A zero request is a no-op: no payout, no done pulse.
                if (bus.change_load && (bus.change_in != 16'd0)) begin
                    remaining_nxt = bus.change_in;
                    shortfall_nxt = 16'd0;
                    short_nxt     = 1'b0;
                    state_nxt     = DISP_SELECT;
                end
            end
            DISP_SELECT: begin
                if (sel_found) begin
                    coin_nxt  = sel_code;
                    state_nxt = DISP_ISSUE;
                end else begin
                    // Nothing payable left: either fully paid, a sub-5
                    // remainder, or the needed coins are out of stock.
                    shortfall_nxt = remaining;
                    short_nxt     = (remaining != 16'd0);
                    coin_nxt      = COIN_NONE;
                    state_nxt     = DISP_FINISH;
                end
            end
            DISP_ISSUE: begin
                if (accept) begin
                    remaining_nxt = remaining - coin_value(coin_q);
                    state_nxt     = DISP_SELECT;
                end
            end
            DISP_FINISH: begin
                state_nxt = DISP_IDLE;
            end
            default: begin
                state_nxt = DISP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining   <= 16'd0;
            shortfall_q <= 16'd0;
            short_q     <= 1'b0;
            coin_q      <= COIN_NONE;
            load_drop_q <= 1'b0;
        end else begin
            remaining   <= remaining_nxt;
            shortfall_q <= shortfall_nxt;
            short_q     <= short_nxt;
            coin_q      <= coin_nxt;
            // Requests arriving mid-payout are discarded; flag them once.
            load_drop_q <= bus.change_load && (state != DISP_IDLE);
        end
    end

    assign bus.coin_out   = coin_q;
    assign bus.coin_valid = (state == DISP_ISSUE);
    assign bus.busy       = (state != DISP_IDLE);
    assign bus.done       = (state == DISP_FINISH);
    assign bus.short_flag = short_q;
    assign bus.shortfall  = shortfall_q;
    assign bus.load_drop  = load_drop_q;

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
// Scenario tasks drive the dispenser through its interface. Expected coin
// sequences, shortfalls and inventory levels come from a reference model
// that pays change greedily with plain arithmetic over an inventory array.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

    logic clk;
    logic reset;

    change_dispenser_if bus();

    change_dispenser #(
        .CNT_W      (8),
        .INIT_COUNT (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, indexed by coin code 1..5.
    int val_m [6] = '{0, 5, 10, 50, 100, 500};
    int inv_m [6];
    int exp_q [$];
    int exp_short;

    // Observations collected by the payout driver.
    int   got_q [$];
    logic obs_sf;
    int   obs_short;
    int   obs_tvalid;
    int   obs_tdone;
    int   obs_drops;
    logic obs_busy_after;
    logic obs_done_after;

    task automatic model_reset();
        for (int d = 1; d <= 5; d++) inv_m[d] = 20;
    endtask

    // Greedy payout over the model inventory; commits the coins it plans.
    task automatic plan(input int amt);
        int rem;
        rem = amt;
        exp_q.delete();
        for (int d = 5; d >= 1; d--) begin
            while (val_m[d] <= rem && inv_m[d] > 0) begin
                exp_q.push_back(d);
                rem      -= val_m[d];
                inv_m[d] -= 1;
            end
        end
        exp_short = rem;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.change_load = 1'b0;
        bus.coin_ready  = 1'b0;
        bus.restock_en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Plans the payout in the model and issues a one-cycle load.
    // Returns at the first falling edge after the load edge (cycle N+1).
    task automatic start_payout(input int amt);
        plan(amt);
        @(negedge clk);
        bus.change_in   = 16'(amt);
        bus.change_load = 1'b1;
        @(negedge clk);
        bus.change_load = 1'b0;
    endtask

    // Runs the payout to its done pulse. rdy_mode 0: ready always high,
    // 1: random ready. drop_at: cycle at which to fire a load while busy.
    // restock5: restock a 5 in the same cycle a 5 is issued.
    task automatic drain_payout(input int rdy_mode, input int drop_at,
                                input bit restock5, input int start_cyc);
        int cyc;
        got_q.delete();
        obs_tvalid = -1;
        obs_tdone  = -1;
        obs_drops  = 0;
        cyc = start_cyc;
        while (cyc < start_cyc + 3000) begin
            if (bus.load_drop) obs_drops++;
            if (bus.coin_valid && obs_tvalid < 0) obs_tvalid = cyc;
            if (bus.done) begin
                obs_tdone = cyc;
                obs_sf    = bus.short_flag;
                obs_short = int'(bus.shortfall);
                break;
            end
            bus.coin_ready  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.change_load = (drop_at == cyc);
            if (drop_at == cyc) bus.change_in = 16'd500;
            bus.restock_en  = 1'b0;
            if (bus.coin_valid && bus.coin_ready) begin
                got_q.push_back(int'(bus.coin_out));
                if (restock5 && bus.coin_out == 3'b001) begin
                    bus.restock_en   = 1'b1;
                    bus.restock_coin = 3'b001;
                    if (inv_m[1] < 255) inv_m[1]++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.change_load = 1'b0;
        bus.restock_en  = 1'b0;
        bus.coin_ready  = 1'b0;
        if (obs_tdone < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL payout_timeout: no done within bound, coins seen %0d required %0d",
                     got_q.size(), exp_q.size());
        end
        @(negedge clk);
        obs_busy_after = bus.busy;
        obs_done_after = bus.done;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.coin_out !== 3'b000) begin n_fail++; $display("FAIL reset_coin_out: got %b required 000", bus.coin_out); end
        n_cmp++; if (bus.coin_valid !== 1'b0) begin n_fail++; $display("FAIL reset_coin_valid: got %b required 0", bus.coin_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.done); end
        n_cmp++; if (bus.short_flag !== 1'b0) begin n_fail++; $display("FAIL reset_short_flag: got %b required 0", bus.short_flag); end
        n_cmp++; if (bus.shortfall !== 16'd0) begin n_fail++; $display("FAIL reset_shortfall: got %0d required 0", bus.shortfall); end
        n_cmp++; if (bus.load_drop !== 1'b0) begin n_fail++; $display("FAIL reset_load_drop: got %b required 0", bus.load_drop); end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin
                n_fail++;
                $display("FAIL reset_inv[%0d]: got %0d required %0d", d, dut.u_inv.cnt[d-1], inv_m[d]);
            end
        end
    endtask

    task automatic test_greedy_665();
        int lit [5] = '{5, 4, 3, 2, 1};
        do_reset();
        start_payout(665);
        drain_payout(0, 0, 1'b0, 1);
        n_cmp++; if (got_q.size() != 5) begin n_fail++; $display("FAIL g665_count: got %0d required 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            n_cmp++;
            if (got_q[i] != lit[i]) begin n_fail++; $display("FAIL g665_coin[%0d]: got %0d required %0d", i, got_q[i], lit[i]); end
        end
        n_cmp++; if (obs_sf !== 1'b0 || obs_short != 0) begin n_fail++; $display("FAIL g665_short: got %b/%0d required 0/0", obs_sf, obs_short); end
        n_cmp++; if (obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin n_fail++; $display("FAIL g665_done_width: busy/done after %b/%b required 0/0", obs_busy_after, obs_done_after); end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== 19) begin n_fail++; $display("FAIL g665_inv[%0d]: got %0d required 19", d, dut.u_inv.cnt[d-1]); end
        end
    endtask

    task automatic test_latency_165();
        do_reset();
        start_payout(165);
        drain_payout(0, 0, 1'b0, 1);
        n_cmp++; if (obs_tvalid != 2) begin n_fail++; $display("FAIL lat_first_valid: got N+%0d required N+2", obs_tvalid); end
        n_cmp++; if (obs_tdone != 10) begin n_fail++; $display("FAIL lat_done: got N+%0d required N+10", obs_tdone); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL lat_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL lat_coin[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_inventory_empty();
        do_reset();
        repeat (20) begin start_payout(100); drain_payout(0, 0, 1'b0, 1); end
        start_payout(200);
        drain_payout(0, 0, 1'b0, 1);
        n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL empty100_count: got %0d required 4", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != 3) begin n_fail++; $display("FAIL empty100_coin[%0d]: got %0d required 3", i, got_q[i]); end
        end
        n_cmp++; if (obs_sf !== 1'b0) begin n_fail++; $display("FAIL empty100_short: got %b required 0", obs_sf); end
        repeat (16) begin start_payout(50); drain_payout(0, 0, 1'b0, 1); end
        start_payout(200);
        drain_payout(0, 0, 1'b0, 1);
        n_cmp++; if (got_q.size() != 20) begin n_fail++; $display("FAIL empty50_count: got %0d required 20", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != 2) begin n_fail++; $display("FAIL empty50_coin[%0d]: got %0d required 2", i, got_q[i]); end
        end
        n_cmp++; if (obs_sf !== 1'b0 || obs_short != 0) begin n_fail++; $display("FAIL empty50_short: got %b/%0d required 0/0", obs_sf, obs_short); end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin n_fail++; $display("FAIL empty_inv[%0d]: got %0d required %0d", d, dut.u_inv.cnt[d-1], inv_m[d]); end
        end
    endtask

    task automatic test_short_13();
        do_reset();
        // A zero-amount load must not start a payout.
        @(negedge clk);
        bus.change_in   = 16'd0;
        bus.change_load = 1'b1;
        @(negedge clk);
        bus.change_load = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_load_busy: got %b required 0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_load_done: got %b required 0", bus.done); end
        start_payout(13);
        drain_payout(0, 0, 1'b0, 1);
        n_cmp++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] != 2)) begin
            n_fail++; $display("FAIL short13_coins: got %0d coins required one coin of code 2", got_q.size());
        end
        n_cmp++; if (obs_sf !== (exp_short != 0)) begin n_fail++; $display("FAIL short13_flag: got %b required 1", obs_sf); end
        n_cmp++; if (obs_short != exp_short) begin n_fail++; $display("FAIL short13_shortfall: got %0d required %0d", obs_short, exp_short); end
        n_cmp++; if (bus.shortfall !== 16'(exp_short)) begin n_fail++; $display("FAIL short13_held: got %0d required %0d", bus.shortfall, exp_short); end
    endtask

    task automatic test_backpressure();
        int   waited;
        logic [2:0] c0;
        do_reset();
        bus.coin_ready = 1'b0;
        start_payout(750);
        waited = 0;
        while (!bus.coin_valid && waited < 20) begin @(negedge clk); waited++; end
        n_cmp++; if (bus.coin_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b required 1", bus.coin_valid); end
        c0 = bus.coin_out;
        repeat (5) begin
            bus.coin_ready = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.coin_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b required 1", bus.coin_valid); end
            n_cmp++; if (bus.coin_out !== c0) begin n_fail++; $display("FAIL bp_hold_coin: got %b required %b", bus.coin_out, c0); end
            n_cmp++; if (dut.remaining !== 16'd750) begin n_fail++; $display("FAIL bp_hold_remaining: got %0d required 750", dut.remaining); end
            n_cmp++; if (int'(dut.u_inv.cnt[4]) !== 20) begin n_fail++; $display("FAIL bp_hold_inv500: got %0d required 20", dut.u_inv.cnt[4]); end
        end
        drain_payout(0, 0, 1'b0, 100);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL bp_coin[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
        end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin n_fail++; $display("FAIL bp_inv[%0d]: got %0d required %0d", d, dut.u_inv.cnt[d-1], inv_m[d]); end
        end
    endtask

    task automatic test_load_drop();
        do_reset();
        start_payout(165);
        drain_payout(0, 3, 1'b1, 1);
        n_cmp++; if (obs_drops != 1) begin n_fail++; $display("FAIL drop_pulses: got %0d required 1", obs_drops); end
        n_cmp++; if (obs_tdone != 10) begin n_fail++; $display("FAIL drop_done_time: got N+%0d required N+10", obs_tdone); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL drop_coin[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (obs_sf !== 1'b0 || obs_short != 0) begin n_fail++; $display("FAIL drop_short: got %b/%0d required 0/0", obs_sf, obs_short); end
        n_cmp++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL drop_second_load: busy %b required 0", obs_busy_after); end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin n_fail++; $display("FAIL drop_inv[%0d]: got %0d required %0d", d, dut.u_inv.cnt[d-1], inv_m[d]); end
        end
    endtask

    task automatic test_restock_sat();
        logic [2:0] bad [3] = '{3'b000, 3'b110, 3'b111};
        do_reset();
        repeat (240) begin
            @(negedge clk);
            bus.restock_en   = 1'b1;
            bus.restock_coin = 3'b101;
            if (inv_m[5] < 255) inv_m[5]++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.restock_en   = 1'b1;
            bus.restock_coin = bad[k];
        end
        @(negedge clk);
        bus.restock_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (int'(dut.u_inv.cnt[4]) !== 255) begin n_fail++; $display("FAIL restock_sat500: got %0d required 255", dut.u_inv.cnt[4]); end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin n_fail++; $display("FAIL restock_inv[%0d]: got %0d required %0d", d, dut.u_inv.cnt[d-1], inv_m[d]); end
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        int dones;
        do_reset();
        bus.coin_ready = 1'b0;
        start_payout(750);
        @(negedge clk);
        bus.coin_ready = 1'b1;
        waited = 0;
        while (!bus.coin_valid && waited < 20) begin @(negedge clk); waited++; end
        bus.coin_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if (bus.coin_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b required 0", bus.coin_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", bus.busy); end
        dones = 0;
        repeat (6) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses required 0", dones); end
        for (int d = 1; d <= 5; d++) begin
            n_cmp++;
            if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin n_fail++; $display("FAIL rstmid_inv[%0d]: got %0d required %0d", d, dut.u_inv.cnt[d-1], inv_m[d]); end
        end
    endtask

    task automatic test_random();
        int amt;
        int code;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                code = int'($urandom_range(0, 7));
                bus.restock_en   = 1'b1;
                bus.restock_coin = 3'(code);
                if (code >= 1 && code <= 5 && inv_m[code] < 255) inv_m[code]++;
            end
            @(negedge clk);
            bus.restock_en = 1'b0;
            amt = int'($urandom_range(1, 2600));
            start_payout(amt);
            drain_payout(1, 0, 1'b0, 1);
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count amt=%0d: got %0d required %0d", t, amt, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_coin[%0d]: got %0d required %0d", t, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (obs_sf !== (exp_short != 0)) begin n_fail++; $display("FAIL rnd%0d_flag: got %b required %b", t, obs_sf, (exp_short != 0)); end
            n_cmp++; if (obs_short != exp_short) begin n_fail++; $display("FAIL rnd%0d_shortfall: got %0d required %0d", t, obs_short, exp_short); end
            for (int d = 1; d <= 5; d++) begin
                n_cmp++;
                if (int'(dut.u_inv.cnt[d-1]) !== inv_m[d]) begin n_fail++; $display("FAIL rnd%0d_inv[%0d]: got %0d required %0d", t, d, dut.u_inv.cnt[d-1], inv_m[d]); end
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.change_in    = 16'd0;
        bus.change_load  = 1'b0;
        bus.coin_ready   = 1'b0;
        bus.restock_coin = 3'b000;
        bus.restock_en   = 1'b0;
        model_reset();
        test_reset();
        test_greedy_665();
        test_latency_165();
        test_inventory_empty();
        test_short_13();
        test_backpressure();
        test_load_drop();
        test_restock_sat();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending FSM. Consumes the 16-bit change value the FSM emits after a refund or an auto-mode shortfall.
- Breaks that value into physical coins with a greedy algorithm, largest denomination first, limited by a per-denomination inventory.
- Issues coins one at a time to the coin hopper over a valid/ready handshake.
- Reports completion and any unpaid shortfall.

Parameters:
- CNT_W, 8, width of each per-denomination inventory counter.
- INIT_COUNT, 20, inventory value of every denomination after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- change_in  in  16  change amount in rupees; sampled when change_load=1.
- change_load  in  1  one-cycle request; connect to (change != 0) from the FSM.
- coin_out  out  3  denomination to eject: 001=₹5, 010=₹10, 011=₹50, 100=₹100, 101=₹500.
- coin_valid  out  1  coin_out is valid; held until accepted.
- coin_ready  in  1  hopper accepts the coin this cycle.
- restock_coin  in  3  denomination code to restock.
- restock_en  in  1  add one coin of restock_coin to inventory.
- busy  out  1  a payout is in progress (state != IDLE).
- done  out  1  one-cycle pulse when a payout ends.
- short_flag  out  1  valid with done: payout was incomplete.
- shortfall  out  16  amount left unpaid; valid with done, held until the next load.
- load_drop  out  1  one-cycle pulse when change_load arrives while busy.

Behaviour:
- Reset (synchronous): state=IDLE, every inventory = INIT_COUNT, remaining=0.
  - Outputs after reset: coin_out=000, coin_valid=0, busy=0, done=0, short_flag=0, shortfall=0, load_drop=0.
  - Reset mid-payout abandons the payout. No done pulse is produced. coin_valid is low the cycle after reset.
- State machine: IDLE, SELECT, ISSUE, FINISH. All registered, one transition per clock.
- IDLE:
  - If change_load=1 and change_in!=0: remaining<=change_in, clear shortfall and short_flag, go to SELECT.
  - If change_load=1 and change_in==0: stay in IDLE, no done pulse.
- SELECT: pick the highest d in {500,100,50,10,5} with value(d) <= remaining and inv[d] > 0.
  - If a d is found: latch coin_out=code(d), go to ISSUE.
  - If none is found: shortfall<=remaining, short_flag<=(remaining!=0), go to FINISH.
  - This covers remainders that are not a multiple of 5 (for example 3) and exhausted inventory.
- ISSUE:
  - coin_valid=1. coin_out stays stable until handshake.
  - On coin_valid and coin_ready: remaining -= value(d), inv[d] -= 1, go to SELECT.
  - coin_ready while coin_valid=0 is ignored.
- FINISH: done=1 for exactly one cycle, then go to IDLE. busy stays high in FINISH.
- Latency:
  - load at cycle N → SELECT at N+1 → coin_valid at N+2.
  - Each accepted coin costs 2 cycles minimum (ISSUE, SELECT).
  - With coin_ready tied high, a ₹165 payout (100, 50, 10, 5) gives done at N+10.
- change_load while busy: the request is dropped and load_drop pulses. The current payout is unaffected.
- Restock:
  - Allowed in any state. Saturates at 2^CNT_W-1. Codes 000, 110 and 111 are ignored.
  - Restock and issue of the same denomination in the same cycle: net inventory change is 0.
- Arithmetic: remaining is 16 bits and never underflows, because a coin is selected only if value <= remaining. Denomination values are zero-extended to 16 bits.

Decomposition:
- Shared package vending_pkg holds:
  - coin code constants, COIN_5..COIN_500;
  - the coin_value function, identical to the decoder used by the FSM;
  - the change_dispenser state encoding.
- One sub-module, coin_inventory, with five CNT_W-bit counters:
  - inputs: restock_en/restock_coin, dec_en/dec_coin;
  - outputs: per-denomination non-empty flags;
  - implements saturation and the simultaneous inc/dec rule.

Test Plan:
- Load ₹665 with coin_ready=1 → coins 101, 100, 011, 010, 001 in order; done with short_flag=0, shortfall=0; inventories 19 each.
- Inventory of ₹100 at 0, load ₹200 → four 011 coins, short_flag=0. Then ₹50 at 0 as well, load ₹200 → twenty 010 coins, done, no shortfall.
- Load ₹13 → coins 010 then none; done with short_flag=1, shortfall=3.
- coin_ready held low 5 cycles in ISSUE → coin_valid and coin_out stable throughout; remaining and inventory unchanged until the ready cycle.
- change_load ₹500 while busy → load_drop pulses once and the first payout completes unchanged. Restock ₹5 in the same cycle as a ₹5 issue → inv[₹5] unchanged.
- Reset asserted during ISSUE of ₹750 → next cycle coin_valid=0, busy=0, no done pulse; inventories = INIT_COUNT.
